// File: rtl/mips_writeback_ctrl.sv
// Register-file write-side controller: result FIFO, drain to the write port, and pending-write scoreboard.
// Optional same-cycle bypass of an empty FIFO is enabled by defining MIPS_WB_BYPASS_EN.
module mips_writeback_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     issue_valid,
   input  logic [4:0]               issue_reg,
   input  logic                     result_valid,
   output logic                     result_ready,
   input  logic [4:0]               result_reg,
   input  logic [31:0]              result_data,
   input  logic                     wb_stall,
   output logic                     RegWrite,
   output logic [4:0]               write_reg,
   output logic [31:0]              write_data,
   input  logic [4:0]               check_reg_1,
   input  logic [4:0]               check_reg_2,
   output logic                     busy_1,
   output logic                     busy_2,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   LP_FULL = (AW+1)'(DEPTH);

   logic [4:0]    r_fifo_reg  [DEPTH];
   logic [31:0]   r_fifo_data [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_pending;

   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_bypass;
   logic [31:0]   w_set_mask;
   logic [31:0]   w_clr_mask;
   logic [31:0]   w_pending_nxt;

   assign w_empty      = (r_count == '0);
   assign result_ready = (r_count < LP_FULL);
   assign w_pop        = !w_empty && !wb_stall;

`ifdef MIPS_WB_BYPASS_EN
   assign w_bypass = w_empty && !wb_stall && result_valid;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed result goes straight to the write port and is never stored.
   assign w_push = result_valid && result_ready && !w_bypass;

   always_comb begin
      RegWrite   = 1'b0;
      write_reg  = '0;
      write_data = '0;
      if (!w_empty) begin
         write_reg  = r_fifo_reg[r_rd_ptr];
         write_data = r_fifo_data[r_rd_ptr];
         RegWrite   = w_pop && (r_fifo_reg[r_rd_ptr] != 5'd0);
      end else if (w_bypass) begin
         write_reg  = result_reg;
         write_data = result_data;
         RegWrite   = (result_reg != 5'd0);
      end
   end

   // Issue set is applied after the write clear so a re-issue to the same index keeps it pending.
   always_comb begin
      w_set_mask    = '0;
      w_clr_mask    = '0;
      if (issue_valid) w_set_mask = 32'd1 << issue_reg;
      if (RegWrite)    w_clr_mask = 32'd1 << write_reg;
      w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_pending <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_reg[r_wr_ptr]  <= result_reg;
         r_fifo_data[r_wr_ptr] <= result_data;
      end
   end

   assign busy_1     = r_pending[check_reg_1];
   assign busy_2     = r_pending[check_reg_2];
   assign fifo_count = r_count;

endmodule
